// File: rtl/mem_fill_responder_pkg.sv
// Shared constants and types for the memory fill responder.
// Holds the data/address widths, the default pipeline latency and array depth,
// the width of the in-flight counter, and the {valid, data} stage struct that
// the read-response pipeline carries.
package mem_fill_responder_pkg;

  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 16;
  localparam int DEF_LATENCY    = 4;
  localparam int DEF_DEPTH_BITS = 10;
  // Counts up to the maximum legal latency (8).
  localparam int INFL_W         = 4;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } pipe_stage_t;

endpackage

// File: rtl/mem_fill_responder_pipe.sv
// fill_resp_pipe: one {valid, data} stage of the read-response pipeline.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears the stage
//   d_i  - stage input
//   q_o  - registered stage output
module fill_resp_pipe
  import mem_fill_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  pipe_stage_t d_i,
  output pipe_stage_t q_o
);

  pipe_stage_t stage_q;

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= d_i;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: fixed-latency single-port word memory.
// Accepts one request per cycle with no backpressure. Writes update the array
// at the end of the request cycle; reads sample the array in the acceptance
// cycle and the result travels down LATENCY {valid, data} stages, emerging as a
// one-cycle data_valid pulse LATENCY cycles later.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   enable, wr  - request valid / request type (1 = write)
//   addr        - byte address, word index = addr[DEPTH_BITS:1]
//   data_in     - write data
//   data_out    - read data, zero whenever data_valid is low
//   data_valid  - read response present this cycle
//   in_flight   - reads accepted but not yet returned
module mem_fill_responder
  import mem_fill_responder_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,    // 1..8
  parameter int DEPTH_BITS = DEF_DEPTH_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [INFL_W-1:0] in_flight
);

  localparam int WORDS = 1 << DEPTH_BITS;

  logic [DATA_W-1:0]   mem_q [WORDS];
  logic [DEPTH_BITS-1:0] widx;
  logic                rd_acc, wr_acc;

  // Upper address bits alias and addr[0] selects a byte lane we never use.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign widx   = addr[DEPTH_BITS:1];
  // Requests arriving during reset are dropped, writes included.
  assign rd_acc = !rst && enable && !wr;
  assign wr_acc = !rst && enable &&  wr;

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[widx] <= data_in;
  end

  // Response pipeline. Data is zeroed at the head when the slot is a bubble,
  // so the tail naturally drives 0 on data_out whenever data_valid is low.
  pipe_stage_t [LATENCY-1:0] pipe_d, pipe_q;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign pipe_d[g].valid = rd_acc;
      assign pipe_d[g].data  = rd_acc ? mem_q[widx] : '0;
    end else begin : g_body
      assign pipe_d[g] = pipe_q[g-1];
    end
    fill_resp_pipe u_stage (
      .clk (clk),
      .rst (rst),
      .d_i (pipe_d[g]),
      .q_o (pipe_q[g])
    );
  end

  assign data_valid = pipe_q[LATENCY-1].valid;
  assign data_out   = pipe_q[LATENCY-1].data;

  // Outstanding-read counter; accept and return in the same cycle cancel.
  logic [INFL_W-1:0] in_flight_q, in_flight_d;

  always_comb begin
    in_flight_d = in_flight_q;
    if (rd_acc && !data_valid)      in_flight_d = in_flight_q + 1'b1;
    else if (!rd_acc && data_valid) in_flight_d = in_flight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) in_flight_q <= '0;
    else     in_flight_q <= in_flight_d;
  end

  assign in_flight = in_flight_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder (LATENCY=4, DEPTH_BITS=10).
// Each cycle: wait for the rising edge, settle 1 time unit, check the outputs
// belonging to that cycle, then drive that cycle's request.
module tb_mem_fill_responder;

  logic        clk = 1'b0;
  logic        rst, enable, wr;
  logic [15:0] addr, data_in, data_out;
  logic        data_valid;
  logic [3:0]  in_flight;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_fill_responder #(.LATENCY(4), .DEPTH_BITS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .in_flight  (in_flight)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic w, input logic [15:0] a,
                       input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic dv, input logic [15:0] d);
    chk({tag, ".valid"}, {15'b0, data_valid}, {15'b0, dv});
    chk({tag, ".data"}, data_out, d);
  endtask

  task automatic chk_infl(input string tag, input int exp);
    chk({tag, ".in_flight"}, {12'b0, in_flight}, exp[15:0]);
  endtask

  initial begin
    int exp_if, ret, peak;
    logic        edv;
    logic [15:0] ed;

    // ---------------- reset state
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk_resp("reset", 1'b0, 16'h0000);
    chk_infl("reset", 0);
    rst = 1'b0;

    // ---------------- single write, idle, read -> response exactly 4 later
    tick(); drive(1'b1, 1'b1, 16'h0010, 16'hA5A5);
    tick(); idle();
    tick(); drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      tick(); idle();
      chk_resp($sformatf("basic.c%0d", k), k == 4, (k == 4) ? 16'hA5A5 : 16'h0000);
      chk_infl($sformatf("basic.c%0d", k), (k <= 4) ? 1 : 0);
    end

    // ---------------- preload 1..8, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      tick(); drive(1'b1, 1'b1, 16'(2 * i), 16'(i + 1));
    end
    peak = 0;
    for (int c = 0; c <= 13; c++) begin
      tick();
      edv = (c >= 4) && (c <= 11);
      ed  = edv ? 16'(c - 3) : 16'h0000;
      ret = (c > 12) ? 8 : ((c > 4) ? c - 4 : 0);
      exp_if = ((c < 8) ? c : 8) - ret;
      chk_resp($sformatf("burst.c%0d", c), edv, ed);
      chk_infl($sformatf("burst.c%0d", c), exp_if);
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (c < 8) drive(1'b1, 1'b0, 16'(2 * c), 16'h0000);
      else       idle();
    end
    chk("burst.peak", peak[15:0], 16'd4);

    // ---------------- read, then overwrite, then re-read same address
    tick(); drive(1'b1, 1'b1, 16'h0020, 16'h1111);
    for (int c = 0; c <= 7; c++) begin
      tick();
      edv = (c == 4) || (c == 6);
      ed  = (c == 4) ? 16'h1111 : ((c == 6) ? 16'h2222 : 16'h0000);
      chk_resp($sformatf("raw.c%0d", c), edv, ed);
      case (c)
        0:       drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        1:       drive(1'b1, 1'b1, 16'h0020, 16'h2222);
        2:       drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        default: idle();
      endcase
    end

    // ---------------- reset with reads in flight; write during reset dropped
    for (int c = 0; c <= 3; c++) begin
      tick();
      if (c < 3) drive(1'b1, 1'b0, 16'(2 * c), 16'h0000);
    end
    chk_infl("rst_mid.pre", 3);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0000, 16'hDEAD);
    for (int c = 4; c <= 11; c++) begin
      tick();
      rst = 1'b0;
      idle();
      chk_resp($sformatf("rst_mid.c%0d", c), 1'b0, 16'h0000);
      chk_infl($sformatf("rst_mid.c%0d", c), 0);
    end
    for (int c = 12; c <= 18; c++) begin
      if (c != 12) tick();
      edv = (c == 16) || (c == 17);
      ed  = (c == 16) ? 16'h0001 : ((c == 17) ? 16'hA5A5 : 16'h0000);
      if (c != 12) chk_resp($sformatf("rst_keep.c%0d", c), edv, ed);
      if (c == 12)      drive(1'b1, 1'b0, 16'h0000, 16'h0000);
      else if (c == 13) drive(1'b1, 1'b0, 16'h0010, 16'h0000);
      else              idle();
    end

    // ---------------- alternating read / idle
    for (int c = 0; c <= 11; c++) begin
      tick();
      edv = (c == 4) || (c == 6) || (c == 8);
      ed  = (c == 6) ? 16'h0003 : (edv ? 16'h0002 : 16'h0000);
      chk_resp($sformatf("alt.c%0d", c), edv, ed);
      if (c == 0 || c == 4) drive(1'b1, 1'b0, 16'h0002, 16'h0000);
      else if (c == 2)      drive(1'b1, 1'b0, 16'h0004, 16'h0000);
      else                  idle();
    end

    // ---------------- aliasing: high bits and addr[0] ignored
    for (int c = 0; c <= 9; c++) begin
      tick();
      edv = (c >= 5) && (c <= 7);
      chk_resp($sformatf("alias.c%0d", c), edv, edv ? 16'hBEEF : 16'h0000);
      case (c)
        0:       drive(1'b1, 1'b1, 16'h0802, 16'hBEEF);
        1:       drive(1'b1, 1'b0, 16'h0002, 16'h0000);
        2:       drive(1'b1, 1'b0, 16'h0003, 16'h0000);
        3:       drive(1'b1, 1'b0, 16'hF802, 16'h0000);
        default: idle();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
